// File: rtl/dcache_direct_if.sv
// Bundle between the memory stage, the data cache and backing memory.
// The cache takes the slave view; the pipeline/memory side takes the master view.
interface dcache_direct_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output req_read, req_write, addr, wdata, byte_en, mem_ready, mem_rdata,
    input  rdata, mem_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_read, req_write, addr, wdata, byte_en, mem_ready, mem_rdata,
    output rdata, mem_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Misses refill a whole line beat by beat; stores always write through to memory.
module dcache_direct #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  dcache_direct_if.slave  bus
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite, StWdone} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*WORDS];

  logic [OFF_W-1:0] beat_q;
  logic [29:0]      lat_word_q;
  logic [31:0]      lat_wdata_q;
  logic [3:0]       lat_be_q;

  logic [29:0]      lk_word;
  logic [OFF_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             hit;
  logic             accept;
  logic             last_beat;

  logic        mem_req, mem_we, mem_stall;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;

  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];

  // Look up the live request in IDLE, the latched one while a transaction is open.
  assign lk_word   = (state_q == StIdle) ? bus.addr[31:2] : lat_word_q;
  assign lk_off    = lk_word[OFF_W-1:0];
  assign lk_idx    = lk_word[OFF_W +: IDX_W];
  assign lk_tag    = lk_word[29 -: TAG_W];
  assign hit       = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign accept    = mem_req && bus.mem_ready;
  assign last_beat = (beat_q == OFF_W'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_write) begin
          state_d = StWrite;
        end else if (bus.req_read && !hit) begin
          state_d = StRefill;
        end
      end
      StRefill: if (accept && last_beat) state_d = StIdle;
      StWrite:  if (accept) state_d = StWdone;
      StWdone:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_stall = 1'b0;
    rdata     = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_write) begin
          mem_stall = 1'b1;
        end else if (bus.req_read) begin
          if (hit) rdata = data_mem[{lk_idx, lk_off}];
          else     mem_stall = 1'b1;
        end
      end
      StRefill: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        mem_addr  = {lat_word_q[29:OFF_W], beat_q, 2'b00};
      end
      StWrite: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_stall = 1'b1;
        mem_addr  = {lat_word_q, 2'b00};
        mem_wdata = lat_wdata_q;
        mem_be    = lat_be_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      beat_q      <= '0;
      lat_word_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          beat_q <= '0;
          if (bus.req_write) begin
            lat_word_q  <= bus.addr[31:2];
            lat_wdata_q <= bus.wdata;
            lat_be_q    <= bus.byte_en;
          end else if (bus.req_read && !hit) begin
            lat_word_q      <= bus.addr[31:2];
            // The victim line is overwritten beat by beat, so it must not hit meanwhile.
            valid_q[lk_idx] <= 1'b0;
          end
        end
        StRefill: begin
          if (accept) begin
            beat_q <= beat_q + OFF_W'(1);
            if (last_beat) valid_q[lk_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q guards every read.
  always_ff @(posedge clk) begin
    if (state_q == StRefill && accept) begin
      data_mem[{lk_idx, beat_q}] <= bus.mem_rdata;
      if (last_beat) tag_mem[lk_idx] <= lk_tag;
    end
    if (state_q == StWrite && accept && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be_q[b]) data_mem[{lk_idx, lk_off}][8*b +: 8] <= lat_wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.rdata     = rdata;
  assign bus.mem_stall = mem_stall;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_be    = mem_be;

endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: scoreboarded memory beats plus a reference cache/memory model.
module tb_dcache_direct;

  localparam int WORDS = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_direct_if bus ();

  dcache_direct #(.SETS(64), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int ws = 0;
  int wait_cnt = 0;
  int beats_seen = 0;
  beat_t exp_q[$];

  logic [31:0] ovr [logic [31:0]];
  logic        mvalid [64];
  logic [21:0] mtag [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Backing memory: ready after ws wait cycles per beat, read data from the model.
  always @(negedge clk) begin
    bus.mem_rdata = mem_word({bus.mem_addr[31:2], 2'b00});
    bus.mem_ready = bus.mem_req && (wait_cnt >= ws);
  end

  always @(posedge clk) begin
    beat_t e;
    if (!rst && bus.mem_req && bus.mem_ready) begin
      beats_seen++;
      checks++;
      wait_cnt = 0;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected addr=%h we=%b", bus.mem_addr, bus.mem_we);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_we !== e.we ||
            (e.we && (bus.mem_wdata !== e.data || bus.mem_be !== e.be))) begin
          errors++;
          $display("FAIL beat got addr=%h we=%b wd=%h be=%b want addr=%h we=%b wd=%h be=%b",
                   bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be,
                   e.addr, e.we, e.data, e.be);
        end
      end
    end else if (bus.mem_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // One pipeline access: predict beats/stall/data, then run until mem_stall drops.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input string name);
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [31:0] wa, old, exp_rd, rd;
    int          exp_stall, stall;
    bit          done;
    beat_t       b;
    idx = a[9:4];
    tg  = a[31:10];
    wa  = {a[31:2], 2'b00};
    if (we) begin
      exp_stall = 2 + ws;
      b.addr = wa; b.we = 1'b1; b.data = wd; b.be = be;
      exp_q.push_back(b);
      old = mem_word(wa);
      for (int k = 0; k < 4; k++) if (be[k]) old[8*k +: 8] = wd[8*k +: 8];
      ovr[wa] = old;
    end else if (mvalid[idx] && mtag[idx] == tg) begin
      exp_stall = 0;
    end else begin
      exp_stall = 1 + WORDS * (1 + ws);
      for (int k = 0; k < WORDS; k++) begin
        b.addr = {a[31:4], 4'(k * 4)}; b.we = 1'b0; b.data = '0; b.be = '0;
        exp_q.push_back(b);
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    exp_rd = mem_word(wa);

    @(posedge clk); #1;
    bus.req_write = we;
    bus.req_read  = !we;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.byte_en   = be;
    stall = 0;
    done  = 1'b0;
    rd    = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!bus.mem_stall) begin
        done = 1'b1;
        rd   = bus.rdata;
      end else begin
        stall++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.req_write = 1'b0;
    bus.req_read  = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout stall still high after %0d cycles", name, stall);
    end
    checks++;
    if (stall != exp_stall) begin
      errors++;
      $display("FAIL %s stall got %0d want %0d", name, stall, exp_stall);
    end
    if (!we) begin
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata got %h want %h", name, rd, exp_rd);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s beats_missing got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.req_read = 1'b0; bus.req_write = 1'b0; bus.addr = '0; bus.wdata = '0; bus.byte_en = '0;
    rst = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req);
    end
    if (bus.mem_stall !== 1'b0) begin
      errors++; $display("FAIL reset_mem_stall got %b want 0", bus.mem_stall);
    end
    rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL idle_mem_we got %b want 0", bus.mem_we);
    end
    if (bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL idle_mem_addr got %h want 0", bus.mem_addr);
    end
    if (bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL idle_mem_wdata got %h want 0", bus.mem_wdata);
    end
    if (bus.mem_be !== 4'h0) begin
      errors++; $display("FAIL idle_mem_be got %b want 0", bus.mem_be);
    end
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL idle_rdata got %h want 0", bus.rdata);
    end
  endtask

  task automatic test_load_miss();
    ws = 0;
    access(1'b0, 32'h0000_0100, '0, '0, "load_miss_100");
  endtask

  task automatic test_load_hit();
    access(1'b0, 32'h0000_0108, '0, '0, "load_hit_108");
  endtask

  task automatic test_store_hit();
    access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, "store_hit_104");
    access(1'b0, 32'h0000_0104, '0, '0, "load_after_store_104");
  endtask

  task automatic test_store_miss();
    ws = 2;  // ready arrives in the third request cycle
    access(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b1111, "store_miss_2000");
    ws = 0;
    access(1'b0, 32'h0000_2000, '0, '0, "load_no_alloc_2000");
  endtask

  task automatic test_conflict();
    access(1'b0, 32'h0000_0100, '0, '0, "conflict_hit_100");
    access(1'b0, 32'h0000_1100, '0, '0, "conflict_miss_1100");
    access(1'b0, 32'h0000_0100, '0, '0, "conflict_remiss_100");
  endtask

  task automatic test_reset_mid_refill();
    int    base;
    bit    reached;
    beat_t b;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    for (int k = 0; k < WORDS; k++) begin
      b.addr = 32'h100 + 32'(k * 4); b.we = 1'b0; b.data = '0; b.be = '0;
      exp_q.push_back(b);
    end
    base = beats_seen;
    @(posedge clk); #1;
    bus.req_read = 1'b1;
    bus.addr     = 32'h0000_0100;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(posedge clk); #1;
      if (beats_seen - base == 2) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL rst_refill_reach beats got %0d want 2", beats_seen - base);
    end
    rst = 1'b1;
    #1;
    checks += 2;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_refill_mem_req got %b want 0", bus.mem_req);
    end
    if (bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_refill_mem_addr got %h want 0", bus.mem_addr);
    end
    exp_q.delete();
    bus.req_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b0, 32'h0000_0100, '0, '0, "after_rst_refill_100");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < WORDS; k++) begin
      access(1'b0, 32'h100 + 32'(k * 4), '0, '0, "hit_sweep");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_refill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-through, no-write-allocate data cache in the memory stage of the pipelined RISC-V core. It serves load and store requests from the execute/memory pipeline register and refills lines from backing memory over a ready-based handshake. While a miss or store write-through is outstanding it drives `mem_stall` to the hazard unit, which holds the pipeline stages.

## Interface
- `SETS`, 64: number of lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_read` in 1: load request this cycle.
- `req_write` in 1: store request this cycle; takes precedence if both are high.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wdata` in 32: store data, already lane-aligned.
- `byte_en` in 4: store byte lanes.
- `rdata` out 32: load word (full word; extension is done downstream).
- `mem_stall` out 1: to the hazard unit; pipeline frozen while high.
- `mem_req` out 1: backing-memory request valid.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: word-aligned beat address.
- `mem_wdata` out 32: write data.
- `mem_be` out 4: write byte enables.
- `mem_ready` in 1: beat completes at the edge where `mem_req && mem_ready`.
- `mem_rdata` in 32: read beat data, valid with `mem_ready`.

## Operation
- Address split: offset = `addr[2+log2(WORDS)-1:2]`; index = next `log2(SETS)` bits; tag = remaining upper bits.
- Storage: valid bit per line (reset to 0). Tag and data arrays are not reset.
- FSM states: IDLE, REFILL, WRITE, WDONE.
- IDLE:
  - Hit when valid[index] and the stored tag equals the request tag.
  - Load hit: `rdata` = data[index][offset] combinationally; `mem_stall`=0.
  - Load miss: `mem_stall`=1 combinationally; go to REFILL; beat counter = 0.
  - Store (hit or miss): `mem_stall`=1; latch addr, wdata, byte_en; go to WRITE.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, beat, 2'b00}.
  - Each accepted beat writes `mem_rdata` into data[index][beat] and increments beat.
  - On the last beat (beat = WORDS-1): write tag, set valid, go to IDLE.
  - The request is re-evaluated in IDLE and now hits.
  - `mem_stall`=1 throughout.
- WRITE:
  - `mem_req`=1, `mem_we`=1, with the latched address, data and `mem_be`.
  - On acceptance: if the line was a hit at that edge, merge the enabled bytes into the cached word. Go to WDONE.
  - A miss does not allocate.
  - `mem_stall`=1.
- WDONE:
  - `mem_stall`=0; the request present this cycle is ignored, because it is the already-completed store and the pipeline advances at this edge.
  - Go to IDLE.
- `mem_req` is 0 in IDLE and WDONE. `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` hold stable while `mem_req` is high and not yet accepted.
- With no request, IDLE keeps `mem_stall`=0 and `rdata` is don't-care.

## Timing
- Reset values: state IDLE, all valid=0, beat=0, `mem_req`=0, `mem_we`=0, `mem_stall`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `rdata`=0 when no hit.
- Reset asserted mid-REFILL or mid-WRITE: drop `mem_req` immediately (asynchronous). The partial line stays invalid. Backing memory must tolerate the abandoned beat.
- Load hit latency: 0 cycles (combinational).
- Load miss with `mem_ready` tied high:
  - Stall cycles 0..WORDS (5 for WORDS=4).
  - Beat k is accepted at the end of cycle k+1.
  - Hit with `mem_stall`=0 in cycle WORDS+1.
- Store with `mem_ready` tied high: stall in cycles 0–1; WDONE in cycle 2 (`mem_stall`=0).
- Extra memory wait states lengthen the stall 1:1.
- The upstream pipeline holds `req_*`, `addr`, `wdata` and `byte_en` stable while `mem_stall`=1.
- A store to a line currently being refilled cannot occur, because the pipeline is stalled.

## Test plan
- Reset, then load 0x0000_0100 with `mem_ready`=1 and memory word n = 0xA000_0000+n:
  - `mem_stall` high for 5 cycles.
  - Beats go to 0x100, 0x104, 0x108, 0x10C.
  - Then `rdata`=0xA000_0040 and `mem_stall`=0.
- Load 0x0000_0108 after that refill: hit, `rdata`=0xA000_0042, zero stall, `mem_req` never rises.
- Store 0xDEAD_BEEF to 0x104 with `byte_en`=0011 (hit):
  - One write beat, `mem_be`=0011, 2 stall cycles.
  - A following load of 0x104 returns 0xA000_BEEF.
- Store to 0x0000_2000 (miss) with a 3-cycle `mem_ready` delay:
  - Stall lasts 4 cycles.
  - A following load of 0x2000 misses, confirming no allocate.
- Conflict eviction (SETS=64, WORDS=4: 0x1100 shares the index of 0x100 with a different tag):
  - Load 0x100, then load 0x1100: the second load misses and refills from 0x1100.
  - Load 0x100 again: misses and refills again.
- Assert `rst` during refill beat 2: `mem_req`=0 at once. After reset, load 0x100 misses and performs a full 4-beat refill.
